// File: rtl/mem_access_unit.sv
// mem_access_unit: handshaked multi-cycle word memory port for the MEM stage.
// Read-first array access after configurable wait states, with range checking.
module mem_access_unit #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_sel,
   input  logic [29:0]         pc_in,
   input  logic [29:0]         addr_in,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                wren,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rdata,
   output logic [DATA_W-1:0]   rdata_delayed,
   output logic                addr_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;
   localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0] WS_LOAD = 4'(WS_M1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   localparam state_t FIRST_ST = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;

   state_t state;
   state_t state_nxt;

   logic              accept;
   logic [29:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wren_q;
   logic [NB-1:0]     be_q;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] idx;
   logic              oor;
   logic              do_write;

   logic [DATA_W-1:0] mem [DEPTH];

   assign accept   = req_valid & req_ready;
   assign idx      = addr_q[ADDR_W-1:0];
   assign oor      = |addr_q[29:ADDR_W];
   assign do_write = (state == S_ACCESS) & wren_q & ~oor;

   // State register; reset aborts any request in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = FIRST_ST;
         end
         S_WAIT: begin
            if (wait_cnt == 4'd0) state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            state_nxt = S_RESP;
         end
         S_RESP: begin
            req_ready = 1'b1;
            rsp_valid = 1'b1;
            state_nxt = req_valid ? FIRST_ST : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Capture the selected address and write payload on accept
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wren_q  <= 1'b0;
         be_q    <= '0;
      end else if (accept) begin
         addr_q  <= req_sel ? pc_in : addr_in;
         wdata_q <= wdata;
         wren_q  <= wren;
         be_q    <= byte_en;
      end
   end

   // Wait-state countdown, loaded on accept
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= 4'd0;
      end else if (accept) begin
         wait_cnt <= WS_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Registered read result and range flag, updated on the access edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata    <= '0;
         addr_err <= 1'b0;
      end else if (state == S_ACCESS) begin
         rdata    <= oor ? '0 : mem[idx];
         addr_err <= oor;
      end
   end

   // Free-running one-cycle delayed copy of rdata
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_delayed <= '0;
      end else begin
         rdata_delayed <= rdata;
      end
   end

   // Byte-lane array write; old word is read in the same edge (read-first)
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < NB; i++) begin
            if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks for mem_access_unit.
// Instance a uses one wait state, instance b uses none.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_a = 1'b0;
   logic        valid_b = 1'b0;
   logic        req_sel = 1'b0;
   logic [29:0] pc_in = '0;
   logic [29:0] addr_in = '0;
   logic [31:0] wdata = '0;
   logic        wren = 1'b0;
   logic [3:0]  byte_en = '0;

   logic        ready_a, rsp_a, err_a;
   logic [31:0] rdata_a, rdd_a;
   logic        ready_b, rsp_b, err_b;
   logic [31:0] rdata_b, rdd_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(1)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(valid_a), .req_ready(ready_a),
      .req_sel(req_sel), .pc_in(pc_in), .addr_in(addr_in),
      .wdata(wdata), .wren(wren), .byte_en(byte_en),
      .rsp_valid(rsp_a), .rdata(rdata_a),
      .rdata_delayed(rdd_a), .addr_err(err_a)
   );

   mem_access_unit #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(0)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(valid_b), .req_ready(ready_b),
      .req_sel(req_sel), .pc_in(pc_in), .addr_in(addr_in),
      .wdata(wdata), .wren(wren), .byte_en(byte_en),
      .rsp_valid(rsp_b), .rdata(rdata_b),
      .rdata_delayed(rdd_b), .addr_err(err_b)
   );

   // One request on instance a (b=0) or b (b=1); lat counts posedges
   // from the accept edge to the edge that consumes the response.
   task automatic xact(input bit b, input bit sel,
                       input logic [29:0] pc, input logic [29:0] ad,
                       input logic [31:0] wd, input bit we,
                       input logic [3:0] be,
                       output logic [31:0] rd, output logic er,
                       output int lat);
      int  n;
      bit  v;
      @(negedge clk);
      req_sel = sel; pc_in = pc; addr_in = ad;
      wdata = wd; wren = we; byte_en = be;
      if (b) valid_b = 1'b1; else valid_a = 1'b1;
      n = 0;
      while (!(b ? ready_b : ready_a) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: no req_ready within 20 clk");
      end
      @(posedge clk);
      #1;
      valid_a = 1'b0; valid_b = 1'b0;
      lat = 0; v = 1'b0; rd = '0; er = 1'b0;
      while (!v && lat < 20) begin
         @(negedge clk);
         v  = b ? rsp_b : rsp_a;
         rd = b ? rdata_b : rdata_a;
         er = b ? err_b : err_a;
         @(posedge clk);
         lat++;
      end
      if (!v) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_timeout: no rsp_valid within 20 clk");
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({ready_a, rsp_a, err_a, ready_b, rsp_b, err_b} !== 6'b100100) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 100100",
                  {ready_a, rsp_a, err_a, ready_b, rsp_b, err_b});
      end
      n_cmp++;
      if ({rdata_a, rdd_a, rdata_b, rdd_b} !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0",
                  {rdata_a, rdd_a, rdata_b, rdd_b});
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(0, 0, 0, 30'd5, 32'h5555_0005, 1, 4'hF, rd, er, lat);
      xact(0, 0, 0, 30'd5, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h5555_0005) begin
         n_bad++;
         $display("FAIL abort_preload: got %h want 55550005", rd);
      end
      @(negedge clk);
      addr_in = 30'd5; wdata = 32'hAAAA_AAAA; wren = 1'b1;
      byte_en = 4'hF; req_sel = 1'b0; valid_a = 1'b1;
      @(posedge clk);
      #1 valid_a = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ready_a !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_in_wait: ready got %b want 0", ready_a);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({ready_a, rsp_a, err_a} !== 3'b100 ||
          rdata_a !== 32'h0 || rdd_a !== 32'h0) begin
         n_bad++;
         $display("FAIL abort_outputs: rdy/rsp/err %b rdata %h rdd %h want 100 0 0",
                  {ready_a, rsp_a, err_a}, rdata_a, rdd_a);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      xact(0, 0, 0, 30'd5, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h5555_0005) begin
         n_bad++;
         $display("FAIL abort_mem: got %h want 55550005", rd);
      end
   endtask

   task automatic test_latency();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(0, 0, 0, 30'h10, 32'h1234_5678, 1, 4'hF, rd, er, lat);
      n_cmp++;
      if (lat !== 3) begin
         n_bad++;
         $display("FAIL lat_write: got %0d want 3", lat);
      end
      xact(0, 0, 0, 30'h10, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (lat !== 3) begin
         n_bad++;
         $display("FAIL lat_read: got %0d want 3", lat);
      end
      n_cmp++;
      if (rd !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL read_data: got %h want 12345678", rd);
      end
      @(negedge clk);
      n_cmp++;
      if (rdd_a !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL rdata_delayed: got %h want 12345678", rdd_a);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(0, 0, 0, 30'd3, 32'hFFFF_FFFF, 1, 4'hF, rd, er, lat);
      xact(0, 0, 0, 30'd3, 32'h0000_0000, 1, 4'b0101, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hFFFF_FFFF) begin
         n_bad++;
         $display("FAIL read_first: got %h want ffffffff", rd);
      end
      xact(0, 0, 0, 30'd3, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hFF00_FF00) begin
         n_bad++;
         $display("FAIL byte_lanes: got %h want ff00ff00", rd);
      end
      xact(0, 0, 0, 30'd3, 32'h1234_0000, 1, 4'h0, rd, er, lat);
      xact(0, 0, 0, 30'd3, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'hFF00_FF00) begin
         n_bad++;
         $display("FAIL be_zero: got %h want ff00ff00", rd);
      end
   endtask

   task automatic test_select();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(0, 0, 0, 30'd7, 32'h7777_0007, 1, 4'hF, rd, er, lat);
      xact(0, 0, 0, 30'd9, 32'h9999_0009, 1, 4'hF, rd, er, lat);
      xact(0, 1, 30'd7, 30'd9, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h7777_0007) begin
         n_bad++;
         $display("FAIL sel_pc: got %h want 77770007", rd);
      end
      xact(0, 0, 30'd7, 30'd9, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (rd !== 32'h9999_0009) begin
         n_bad++;
         $display("FAIL sel_addr: got %h want 99990009", rd);
      end
   endtask

   task automatic test_range();
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(0, 0, 0, 30'd0, 32'h0BAD_0000, 1, 4'hF, rd, er, lat);
      xact(0, 0, 0, 30'h1000, 32'hDEAD_BEEF, 1, 4'hF, rd, er, lat);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL range_err: err %b rdata %h want 1 0", er, rd);
      end
      @(negedge clk);
      n_cmp++;
      if (err_a !== 1'b1) begin
         n_bad++;
         $display("FAIL range_hold: got %b want 1", err_a);
      end
      xact(0, 0, 0, 30'd0, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0 || rd !== 32'h0BAD_0000) begin
         n_bad++;
         $display("FAIL range_clear: err %b rdata %h want 0 0bad0000", er, rd);
      end
      xact(0, 0, 0, 30'hFFF, 32'hCAFE_0FFF, 1, 4'hF, rd, er, lat);
      xact(0, 0, 0, 30'hFFF, 32'h0, 0, 4'h0, rd, er, lat);
      n_cmp++;
      if (er !== 1'b0 || rd !== 32'hCAFE_0FFF) begin
         n_bad++;
         $display("FAIL top_word: err %b rdata %h want 0 cafe0fff", er, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] exp_d [4];
      int          k;
      int          r;
      int          last;
      bit          rdy;
      bit          v;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         exp_d[i] = 32'hB0B0_0020 + 32'(i * 17);
         xact(1, 0, 0, 30'h20 + 30'(i), exp_d[i], 1, 4'hF, rd, er, lat);
      end
      n_cmp++;
      if (lat !== 2) begin
         n_bad++;
         $display("FAIL lat_ws0: got %0d want 2", lat);
      end
      @(negedge clk);
      req_sel = 1'b0; wren = 1'b0; byte_en = 4'h0;
      addr_in = 30'h20; valid_b = 1'b1;
      k = 0; r = 0; last = -1;
      for (int c = 0; c < 30 && r < 4; c++) begin
         if (c > 0) @(negedge clk);
         rdy = ready_b; v = rsp_b; d = rdata_b;
         if (v) begin
            n_cmp++;
            if (d !== exp_d[r]) begin
               n_bad++;
               $display("FAIL b2b_data%0d: got %h want %h", r, d, exp_d[r]);
            end
            if (last >= 0) begin
               n_cmp++;
               if (c - last != 2) begin
                  n_bad++;
                  $display("FAIL b2b_gap%0d: got %0d want 2", r, c - last);
               end
            end
            last = c;
            r++;
         end
         if (r < 4) begin
            @(posedge clk);
            if (rdy && valid_b) begin
               k++;
               #1;
               if (k < 4) addr_in = 30'h20 + 30'(k);
               else valid_b = 1'b0;
            end
         end
      end
      valid_b = 1'b0;
      n_cmp++;
      if (r !== 4 || k !== 4) begin
         n_bad++;
         $display("FAIL b2b_count: rsp %0d acc %0d want 4 4", r, k);
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_latency();
      test_byte_lanes();
      test_select();
      test_range();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
